hex_display_arbiter: RTL
========================

Name: hex_display_arbiter

Overview:
- Shares the six-digit HEX display (d0..d5, 4-bit codes into the seven-segment decoders) among three requesting sources.
- Requesters are, for example, the stopwatch, the reaction-timer result and the error/status readout.
- Grants use round-robin arbitration with a minimum dwell time.
- With no requester active, the arbiter drives the idle blink pattern itself: all digits 0 for half a period, then all 4'b1111 (blank) for half a period.
- Sits between the source blocks and the per-digit decoders, clocked by the 1 kHz ms_clk.

Parameters:
- DWELL_MS, 1000: ms_clk cycles an owner keeps the display before a waiting requester may preempt it. Legal range 1..65535.
- BLINK_PERIOD, 200: full idle blink period in ms_clk cycles. Must be even, 2..65534.

Ports:
- ms_clk  input  1  1 kHz system clock; all logic is on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- req  input  3  request from source i; held high while source i wants the display.
- src0_digits  input  24  source 0 digits; [3:0]=d0 … [23:20]=d5.
- src1_digits  input  24  source 1 digits, same packing.
- src2_digits  input  24  source 2 digits, same packing.
- grant  output  3  one-hot current owner; 3'b000 when idle.
- idle  output  1  high while the idle blink pattern is displayed.
- d0..d5  output  4 each  digit codes to the decoders.

Behaviour:
- Clock and reset:
  - One clock, ms_clk. Reset is synchronous and active-high; it is sampled on the ms_clk rising edge and dominates every other event.
- Reset values:
  - grant=3'b000, idle=1, d0..d5=4'b0000.
  - dwell_cnt=0, blink_cnt=0.
  - last_grant=2, so source 0 has first priority.
- States: IDLE and OWN. All outputs are registered.
- IDLE:
  - blink_cnt counts 0..BLINK_PERIOD-1 and wraps to 0.
  - blink_cnt < BLINK_PERIOD/2: d*=4'b0000. Otherwise: d*=4'b1111.
  - If req≠0 on an edge: pick the first set bit, searching from last_grant+1 mod 3 upward with wrap.
  - On that same edge: grant=onehot(pick), last_grant=pick, dwell_cnt=0, idle=0, go to OWN.
  - d* takes the picked source's digits on that same edge.
- OWN, with owner k:
  - Each edge: d* registered from srck_digits, giving 1-cycle latency from source to output.
  - dwell_cnt increments and saturates at DWELL_MS-1.
- OWN transitions, evaluated in priority order:
  1. req[k]=0 and other requests pending: switch directly to the round-robin pick among the other requesters. grant changes in one edge with no 3'b000 gap. dwell_cnt=0. d* loads the new source.
  2. req[k]=0 and no other request: go to IDLE. grant=0, idle=1, blink_cnt=0, d*=4'b0000 on that edge.
  3. dwell_cnt==DWELL_MS-1 and some req[j], j≠k, pending: preempt to the round-robin pick. dwell_cnt=0.
  4. Otherwise: stay with owner k.
- The preempted owner keeps req high and is re-served in round-robin order.
- Boundary conditions:
  - Owner drops req on the same edge its dwell expires: treat as release (rule 1 or 2).
  - A single requester never loses the display, whatever its dwell count.
  - A new request arriving while the owner is still in dwell waits; the owner is not preempted early.
  - DWELL_MS=1: ownership may rotate every cycle while several requests are held.
  - Reset mid-operation: all state returns to reset values on that edge. The next pick after reset starts at source 0.
  - grant is always one-hot or zero. idle==1 iff grant==0.
- Widths: dwell_cnt and blink_cnt are 16 bits; comparisons are unsigned.

Test Plan:
- Reset high 2 cycles, req=0, BLINK_PERIOD=200 -> idle=1, grant=0. d*=0 for cycles 0–99, d*=4'hF for cycles 100–199, repeating.
- req=3'b010 with src1_digits=24'h123456, from idle -> next edge grant=3'b010, idle=0. One edge later d5..d0=1,2,3,4,5,6.
- req=3'b111 held, DWELL_MS=4 -> grant sequence 001 (4 cycles), 010 (4), 100 (4), 001, … with no zero gaps.
- Owner 0 drops req at dwell count 1 while req[2]=1 -> grant goes 001→100 on one edge, dwell restarts at 0. Then req=0 -> grant=0, idle=1, d*=0 and the blink phase restarts.
- Reset asserted while grant=3'b100 and req=3'b111 -> grant=0, d*=0 on that edge. After reset release the first grant is 3'b001.
- DWELL_MS=1000, only req[0]=1 held 3000 cycles -> grant stays 3'b001 throughout.

Source files
------------

// File: rtl/hex_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_arbiter
// Purpose  : Shares the six-digit HEX display among three requesting sources.
//            Uses round-robin arbitration with a minimum dwell time per owner.
//            With no requester active it shows an idle blink pattern:
//            all zeros for half a period, then all blanks (4'hF).
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_arbiter #(
  parameter int DWELL_MS     = 1000,  // cycles an owner keeps the display before preemption
  parameter int BLINK_PERIOD = 200    // full idle blink period, even, >= 2
) (
  input  logic        ms_clk,
  input  logic        Reset,
  input  logic [2:0]  req,
  input  logic [23:0] src0_digits,
  input  logic [23:0] src1_digits,
  input  logic [23:0] src2_digits,
  output logic [2:0]  grant,
  output logic        idle,
  output logic [3:0]  d0,
  output logic [3:0]  d1,
  output logic [3:0]  d2,
  output logic [3:0]  d3,
  output logic [3:0]  d4,
  output logic [3:0]  d5
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [15:0] DWELL_LAST = 16'(DWELL_MS - 1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_PERIOD - 1);
  localparam logic [15:0] BLINK_HALF = 16'(BLINK_PERIOD / 2);
  localparam logic [23:0] ALL_ZERO   = 24'h000000;
  localparam logic [23:0] ALL_BLANK  = 24'hFFFFFF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t      state;
  logic [1:0]  last_grant;   // index of the current/most recent owner
  logic [15:0] dwell_cnt;
  logic [15:0] blink_cnt;
  logic [23:0] disp;         // packed d5..d0, registered

  // --------------------------------------------------------------------------
  // Helper functions
  // --------------------------------------------------------------------------

  // Round-robin pick: first set bit searching upward from last+1 (mod 3).
  // Callers only use the result when r is non-zero.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [3:0] rx;
    logic [1:0] first;
    logic [1:0] second;
    logic [1:0] third;
    rx = {1'b0, r};
    case (last)
      2'd0:    begin first = 2'd1; second = 2'd2; third = 2'd0; end
      2'd1:    begin first = 2'd2; second = 2'd0; third = 2'd1; end
      default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
    endcase
    if (rx[first])       rr_pick = first;
    else if (rx[second]) rr_pick = second;
    else                 rr_pick = third;
  endfunction

  // One-hot encoding of a source index.
  function automatic logic [2:0] onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Combinational next-state helpers
  // --------------------------------------------------------------------------
  logic [3:0]  req_x;
  logic        owner_req;
  logic [2:0]  other_req;
  logic [1:0]  idle_pick;
  logic [1:0]  other_pick;
  logic [15:0] blink_next;
  logic [15:0] dwell_next;
  logic [23:0] idle_pick_digits;
  logic [23:0] other_pick_digits;
  logic [23:0] owner_digits;

  assign req_x      = {1'b0, req};
  assign owner_req  = req_x[last_grant];
  // In OWN, last_grant is the owner, so masking it leaves the waiting requesters.
  assign other_req  = req & ~onehot(last_grant);
  assign idle_pick  = rr_pick(req, last_grant);
  assign other_pick = rr_pick(other_req, last_grant);
  assign blink_next = (blink_cnt == BLINK_LAST) ? 16'd0 : blink_cnt + 16'd1;
  assign dwell_next = (dwell_cnt == DWELL_LAST) ? dwell_cnt : dwell_cnt + 16'd1;

  // Digit mux for the three possible sources (new pick from idle, new pick
  // while owned, and the current owner).
  always_comb begin
    idle_pick_digits  = src0_digits;
    other_pick_digits = src0_digits;
    owner_digits      = src0_digits;
    case (idle_pick)
      2'd1:    idle_pick_digits = src1_digits;
      2'd2:    idle_pick_digits = src2_digits;
      default: idle_pick_digits = src0_digits;
    endcase
    case (other_pick)
      2'd1:    other_pick_digits = src1_digits;
      2'd2:    other_pick_digits = src2_digits;
      default: other_pick_digits = src0_digits;
    endcase
    case (last_grant)
      2'd1:    owner_digits = src1_digits;
      2'd2:    owner_digits = src2_digits;
      default: owner_digits = src0_digits;
    endcase
  end

  // --------------------------------------------------------------------------
  // Arbiter FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge ms_clk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      grant      <= 3'b000;
      idle       <= 1'b1;
      last_grant <= 2'd2;      // source 0 gets first priority after reset
      dwell_cnt  <= 16'd0;
      blink_cnt  <= 16'd0;
      disp       <= ALL_ZERO;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req != 3'b000) begin
            state      <= ST_OWN;
            grant      <= onehot(idle_pick);
            idle       <= 1'b0;
            last_grant <= idle_pick;
            dwell_cnt  <= 16'd0;
            disp       <= idle_pick_digits;
          end else begin
            // Digits always reflect the phase of the blink counter value held.
            blink_cnt <= blink_next;
            disp      <= (blink_next < BLINK_HALF) ? ALL_ZERO : ALL_BLANK;
          end
        end

        ST_OWN: begin
          if (!owner_req) begin
            if (other_req != 3'b000) begin
              // Release with others waiting: hand over without a zero-grant gap.
              grant      <= onehot(other_pick);
              last_grant <= other_pick;
              dwell_cnt  <= 16'd0;
              disp       <= other_pick_digits;
            end else begin
              // Release with nobody waiting: blink phase restarts from zero.
              state     <= ST_IDLE;
              grant     <= 3'b000;
              idle      <= 1'b1;
              blink_cnt <= 16'd0;
              disp      <= ALL_ZERO;
            end
          end else if ((dwell_cnt == DWELL_LAST) && (other_req != 3'b000)) begin
            // Dwell expired and someone else is waiting: preempt.
            grant      <= onehot(other_pick);
            last_grant <= other_pick;
            dwell_cnt  <= 16'd0;
            disp       <= other_pick_digits;
          end else begin
            dwell_cnt <= dwell_next;
            disp      <= owner_digits;
          end
        end

        default: begin
          state <= ST_IDLE;
          grant <= 3'b000;
          idle  <= 1'b1;
          disp  <= ALL_ZERO;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output unpacking
  // --------------------------------------------------------------------------
  assign d0 = disp[3:0];
  assign d1 = disp[7:4];
  assign d2 = disp[11:8];
  assign d3 = disp[15:12];
  assign d4 = disp[19:16];
  assign d5 = disp[23:20];

endmodule
`default_nettype wire
